// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: binary-angle format (2^32 = 360 deg), arctangent table,
// and the vectoring FSM state type.
package cordic_pkg;

    localparam int ANGLE_W = 32;

    localparam logic [ANGLE_W-1:0] ANGLE_90  = 32'h4000_0000;
    localparam logic [ANGLE_W-1:0] ANGLE_M90 = 32'hC000_0000;

    // atan(2^-i) scaled to the 32-bit binary angle, i = 0..30
    localparam logic [ANGLE_W-1:0] ATAN_TABLE [0:30] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001
    };

    typedef enum logic [1:0] {
        IDLE,
        ITERATE,
        GAIN,
        DONE
    } cordic_vec_state_t;

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation: drives Y toward zero and
// accumulates the rotated angle into Z.
module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int W = 19
) (
    input  logic signed [W-1:0]       x,
    input  logic signed [W-1:0]       y,
    input  logic [ANGLE_W-1:0]        z,
    input  logic [4:0]                i,
    output logic signed [W-1:0]       x_out,
    output logic signed [W-1:0]       y_out,
    output logic [ANGLE_W-1:0]        z_out
);

    logic signed [W-1:0]  x_sh;
    logic signed [W-1:0]  y_sh;
    logic [ANGLE_W-1:0]   atan;

    always_comb begin
        atan = '0;
        if (i <= 5'd30) begin
            atan = ATAN_TABLE[i];
        end
        x_sh = x >>> i;
        y_sh = y >>> i;
        if (!y[W-1]) begin
            x_out = x + y_sh;
            y_out = y - x_sh;
            z_out = z + atan;
        end else begin
            x_out = x - y_sh;
            y_out = y + x_sh;
            z_out = z - atan;
        end
    end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring CORDIC: (x, y) -> magnitude and atan2 phase, one micro-rotation
// per clock. Define CORDIC_VEC_GAIN_COMP_EN to add the K ~= 0.609375 gain stage.
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int C_PARAMETER = 16,
    parameter int ITER        = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [C_PARAMETER-1:0]   x_in,
    input  logic [C_PARAMETER-1:0]   y_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [C_PARAMETER+1:0]   magnitude,
    output logic [ANGLE_W-1:0]       phase,
    output logic                     busy
);

    localparam int         IW   = C_PARAMETER + 3;
    localparam logic [4:0] LAST = 5'(ITER - 1);

    cordic_vec_state_t      state_q, state_d;
    logic signed [IW-1:0]   x_q, y_q;
    logic [ANGLE_W-1:0]     z_q;
    logic [4:0]             cnt_q;
    logic                   zero_q;

    logic signed [IW-1:0]   x_ext, y_ext;
    logic signed [IW-1:0]   x_nx, y_nx;
    logic [ANGLE_W-1:0]     z_nx;

    assign x_ext = {{3{x_in[C_PARAMETER-1]}}, x_in};
    assign y_ext = {{3{y_in[C_PARAMETER-1]}}, y_in};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    cordic_vec_stage #(.W(IW)) u_stage (
        .x     (x_q),
        .y     (y_q),
        .z     (z_q),
        .i     (cnt_q),
        .x_out (x_nx),
        .y_out (y_nx),
        .z_out (z_nx)
    );

`ifdef CORDIC_VEC_GAIN_COMP_EN
    logic signed [IW-1:0] x_comp;
    assign x_comp = (x_q >>> 1) + (x_q >>> 4) + (x_q >>> 5) + (x_q >>> 6);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ITERATE;
            ITERATE: if (cnt_q == LAST) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                state_d = GAIN;
`else
                state_d = DONE;
`endif
            end
            GAIN:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pre-rotation by +/-90 deg folds the left half-plane into the convergence range.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            cnt_q     <= '0;
            zero_q    <= 1'b0;
            magnitude <= '0;
            phase     <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    zero_q <= (x_in == '0) && (y_in == '0);
                    cnt_q  <= '0;
                    if (!x_ext[IW-1]) begin
                        x_q <= x_ext;
                        y_q <= y_ext;
                        z_q <= '0;
                    end else if (!y_ext[IW-1]) begin
                        x_q <= y_ext;
                        y_q <= -x_ext;
                        z_q <= ANGLE_90;
                    end else begin
                        x_q <= -y_ext;
                        y_q <= x_ext;
                        z_q <= ANGLE_M90;
                    end
                end
                ITERATE: begin
                    x_q   <= x_nx;
                    y_q   <= y_nx;
                    z_q   <= z_nx;
                    cnt_q <= cnt_q + 5'd1;
`ifndef CORDIC_VEC_GAIN_COMP_EN
                    if (cnt_q == LAST) begin
                        magnitude <= zero_q ? '0 : (C_PARAMETER+2)'(x_nx);
                        phase     <= zero_q ? '0 : z_nx;
                    end
`endif
                end
`ifdef CORDIC_VEC_GAIN_COMP_EN
                GAIN: begin
                    magnitude <= zero_q ? '0 : (C_PARAMETER+2)'(x_comp);
                    phase     <= zero_q ? '0 : z_q;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vector.sv
// Scoreboard bench for cordic_vector: expected magnitude/phase come from real-valued
// atan2/hypot scaled by the CORDIC gain; honours CORDIC_VEC_GAIN_COMP_EN.
module tb_cordic_vector;

    localparam int C_W  = 16;
    localparam int NIT  = 16;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int  LAT      = NIT + 2;
    localparam real GAIN_ADJ = 0.609375;
`else
    localparam int  LAT      = NIT + 1;
    localparam real GAIN_ADJ = 1.0;
`endif
    localparam real PI = 3.14159265358979323846;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [C_W-1:0]  x_in = '0;
    logic [C_W-1:0]  y_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [C_W+1:0]  magnitude;
    logic [31:0]     phase;
    logic            busy;

    cordic_vector #(.C_PARAMETER(C_W), .ITER(NIT)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .magnitude (magnitude),
        .phase     (phase),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int x; int y; int acc; } exp_t;
    exp_t sb[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  bp_hold  = 1'b0;
    bit  rand_bp  = 1'b0;

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Product of sqrt(1 + 2^-2i) over all micro-rotations, times the optional compensation.
    function automatic real cordic_gain();
        real k = 1.0;
        for (int i = 0; i < NIT; i++) k = k * $sqrt(1.0 + 2.0 ** (-2.0 * i));
        return k * GAIN_ADJ;
    endfunction

    task automatic model(input int x, input int y, output real mag, output logic [31:0] ph,
                         output real tol_m, output longint tol_p);
        real r, a;
        longint li;
        r = $sqrt(1.0 * x * x + 1.0 * y * y);
        if (x == 0 && y == 0) begin
            mag = 0.0; ph = '0; tol_m = 0.0; tol_p = 0;
        end else begin
            mag   = r * cordic_gain();
            a     = $atan2(1.0 * y, 1.0 * x) * 4294967296.0 / (2.0 * PI);
            li    = longint'(a);
            ph    = li[31:0];
            tol_m = 24.0 + r / 2048.0;
            tol_p = 131072 + longint'(40.0 / r * 4294967296.0 / (2.0 * PI));
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            if (bp_hold)      out_ready = 1'b0;
            else if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            else              out_ready = 1'b1;
        end
    end

    // Monitor: latency on first sight of out_valid, value check on handshake.
    initial begin
        bit seen = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1'b0, longint'(magnitude), 0);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc == sb[0].acc + LAT - 1, cyc - sb[0].acc + 1, LAT);
                        seen = 1'b1;
                    end
                    if (out_ready) begin
                        real em, tm, dm;
                        logic [31:0] ep;
                        longint tp;
                        logic signed [31:0] dp;
                        int m;
                        model(sb[0].x, sb[0].y, em, ep, tm, tp);
                        m  = int'($signed(magnitude));
                        dm = 1.0 * m - em;
                        if (dm < 0.0) dm = -dm;
                        dp = phase - ep;
                        chk($sformatf("magnitude(%0d,%0d)", sb[0].x, sb[0].y), dm <= tm,
                            m, longint'(em));
                        chk($sformatf("phase(%0d,%0d)", sb[0].x, sb[0].y),
                            (dp < 0 ? -longint'(dp) : longint'(dp)) <= tp, phase, ep);
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input int x, input int y);
        int t = 0;
        in_valid = 1'b1;
        x_in = 16'(x);
        y_in = 16'(y);
        while (!in_ready && t < 500) begin
            @(posedge clock); #1;
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 1'b0, 0, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clock); #1;
            sb.push_back('{x: x, y: y, acc: cyc});
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(posedge clock); #1;
            t++;
        end
        chk("drain", sb.size() == 0, sb.size(), 0);
    endtask

    initial begin
        logic [C_W+1:0] mag0;
        logic [31:0]    ph0;
        int t;

        #2;
        chk("rst_in_ready",  in_ready == 1'b1, in_ready, 1);
        chk("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("rst_busy",      busy == 1'b0, busy, 0);
        chk("rst_magnitude", magnitude == '0, magnitude, 0);
        chk("rst_phase",     phase == '0, phase, 0);
        #20 reset_n = 1'b1;
        @(posedge clock); #1;

        send(16384, 0);
        send(0, 16384);
        send(-16384, 0);
        send(-32768, -32768);
        send(0, 0);
        send(32767, -32768);
        send(-1000, 2500);
        drain();

        // Backpressure: result must hold and new input must be refused.
        bp_hold = 1'b1;
        @(posedge clock); #1;
        send(1000, -2000);
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clock); #1;
            t++;
        end
        chk("bp_out_valid", out_valid == 1'b1, out_valid, 1);
        mag0 = magnitude;
        ph0  = phase;
        in_valid = 1'b1;
        x_in = 16'(7);
        y_in = 16'(9);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            chk("bp_hold_valid", out_valid == 1'b1, out_valid, 1);
            chk("bp_in_ready",   in_ready == 1'b0, in_ready, 0);
            chk("bp_mag_stable", magnitude == mag0, magnitude, mag0);
            chk("bp_ph_stable",  phase == ph0, phase, ph0);
        end
        in_valid = 1'b0;
        bp_hold  = 1'b0;
        drain();

        // Reset in the middle of ITERATE (i = 7) discards the sample.
        send(5000, 3000);
        repeat (7) begin
            @(posedge clock); #1;
        end
        chk("pre_rst_busy", busy == 1'b1, busy, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("midrst_in_ready",  in_ready == 1'b1, in_ready, 1);
        sb.delete();
        #2 reset_n = 1'b1;
        @(posedge clock); #1;
        send(-7000, -12000);
        drain();

        rand_bp = 1'b1;
        for (int n = 0; n < 25; n++) begin
            send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        end
        drain();
        rand_bp = 1'b0;

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
